prbs_os_gen: RTL



---
 rtl/prbs_os_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/prbs_os_gen.sv
// PRBS7/11/15/31 ordered-set generator, DATA_W bits per clock, earliest bit in the MSB.
// Optional error injection (err_inj / err_cnt) is built when PRBS_ERR_INJ_EN is defined.
module prbs_os_gen #(
    parameter int unsigned DATA_W = 1,
    parameter int unsigned OS_LEN = 448,
    parameter logic [30:0] SEED   = 31'h7FFFFFFF,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              restart,
    input  logic [1:0]        mode,
`ifdef PRBS_ERR_INJ_EN
    input  logic              err_inj,
    output logic [7:0]        err_cnt,
`endif
    output logic [DATA_W-1:0] data_out,
    output logic              os_sent,
    output logic [CNT_W-1:0]  os_count,
    output logic              busy
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int unsigned WORDS = OS_LEN / DATA_W;
    localparam int unsigned WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS - 1);

    // Seed slice for polynomial length N; an all-zero slice would lock up the LFSR.
    function automatic logic [30:0] seed_for(input logic [1:0] m);
        logic [30:0] mask;
        logic [30:0] s;
        mask = 31'h7FFF_FFFF;
        unique case (m)
            2'b00: mask = 31'h0000_007F;
            2'b01: mask = 31'h0000_07FF;
            2'b10: mask = 31'h0000_7FFF;
            2'b11: mask = 31'h7FFF_FFFF;
        endcase
        s = SEED & mask;
        if (s == '0) s = mask;
        return s;
    endfunction

    function automatic logic [30:0] lfsr_step(input logic [30:0] l, input logic [1:0] m);
        logic [30:0] n;
        n = l;
        unique case (m)
            2'b00: n = {24'd0, l[5:0],  l[6]  ^ l[5]};
            2'b01: n = {20'd0, l[9:0],  l[10] ^ l[8]};
            2'b10: n = {16'd0, l[13:0], l[14] ^ l[13]};
            2'b11: n = {l[29:0], l[30] ^ l[27]};
        endcase
        return n;
    endfunction

    function automatic logic lfsr_msb(input logic [30:0] l, input logic [1:0] m);
        logic b;
        b = l[30];
        unique case (m)
            2'b00: b = l[6];
            2'b01: b = l[10];
            2'b10: b = l[14];
            2'b11: b = l[30];
        endcase
        return b;
    endfunction

    state_t           state_q, state_d;
    logic             enable_q, enable_d;
    logic [30:0]      lfsr_q, lfsr_d;
    logic [1:0]       mode_q, mode_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0] os_count_q, os_count_d;
    logic [30:0]      lfsr_adv;
    logic [31:0]      stream;
    logic             run;
    logic             sent;

    assign run  = (state_q == RUN);
    assign sent = run && (wcnt_q == LAST_WORD);

    always_comb begin
        lfsr_adv = lfsr_q;
        stream   = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            stream   = {stream[30:0], lfsr_msb(lfsr_adv, mode_q)};
            lfsr_adv = lfsr_step(lfsr_adv, mode_q);
        end
    end

    always_comb begin
        enable_d   = enable;
        state_d    = enable_q ? RUN : IDLE;
        mode_d     = mode_q;
        lfsr_d     = lfsr_q;
        wcnt_d     = wcnt_q;
        os_count_d = os_count_q;
        if (!run) begin
            lfsr_d = seed_for(mode);
            wcnt_d = '0;
            mode_d = mode;
        end else begin
            // restart only reseeds; a set finishing in the same cycle is still counted
            os_count_d = os_count_q + (sent ? CNT_W'(1) : CNT_W'(0));
            if (restart) begin
                lfsr_d = seed_for(mode_q);
                wcnt_d = '0;
            end else begin
                lfsr_d = lfsr_adv;
                wcnt_d = sent ? '0 : wcnt_q + WC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            enable_q   <= 1'b0;
            lfsr_q     <= seed_for(2'b01);
            mode_q     <= 2'b01;
            wcnt_q     <= '0;
            os_count_q <= '0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            lfsr_q     <= lfsr_d;
            mode_q     <= mode_d;
            wcnt_q     <= wcnt_d;
            os_count_q <= os_count_d;
        end
    end

    assign os_sent  = sent;
    assign os_count = os_count_q;
    assign busy     = run;

`ifdef PRBS_ERR_INJ_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       inject;

    assign inject = run && err_inj;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (inject && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;

    always_comb begin
        data_out           = stream[DATA_W-1:0];
        data_out[DATA_W-1] = stream[DATA_W-1] ^ inject;
    end
`else
    assign data_out = stream[DATA_W-1:0];
`endif

endmodule
